// File: rtl/psi_pkg.sv
// Shared types and constants for the PSI match-extract block.
package psi_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  localparam int W_DEF = 16;
  localparam int K_DEF = 8;

  // A K-element array holds at most K/2 disjoint pairs, so the count must reach K/2.
  function automatic int cw_f(input int k);
    return $clog2(k / 2 + 1);
  endfunction

endpackage

// File: rtl/psi_pair_select.sv
// Picks element idx and element idx+1 out of the packed array and compares them.
// Out-of-range indices read as zero. The caller never acts on the result in that case.
module psi_pair_select #(
  parameter int W  = 16,
  parameter int K  = 8,
  parameter int IW = $clog2(K) + 1
) (
  input  logic [W*K-1:0] arr_i,
  input  logic [IW-1:0]  idx_i,
  output logic [W-1:0]   elem_o,
  output logic           eq_o
);

  logic [IW-1:0] idx_p1;
  logic [W-1:0]  nxt;

  assign idx_p1 = idx_i + IW'(1);

  // Mux both neighbours of the pair out of the array
  always_comb begin
    elem_o = '0;
    nxt    = '0;
    for (int i = 0; i < K; i++) begin
      if (idx_i  == IW'(i)) elem_o = arr_i[i*W +: W];
      if (idx_p1 == IW'(i)) nxt    = arr_i[i*W +: W];
    end
  end

  assign eq_o = (elem_o == nxt);

endmodule

// File: rtl/psi_match_extract.sv
// Scans a sorted K-element array and streams out every value that appears
// in an adjacent equal pair, then reports the match count and pulses done.
// Optional macro PSI_MATCH_IDX_EN adds out_idx (array index of the pair's first element).
module psi_match_extract
  import psi_pkg::*;
#(
  parameter  int W  = W_DEF,
  parameter  int K  = K_DEF,
  localparam int CW = cw_f(K)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W*K-1:0] in_array,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [CW-1:0]  match_count,
  output logic           done
`ifdef PSI_MATCH_IDX_EN
  , output logic [$clog2(K)-1:0] out_idx
`endif
);

  // One extra bit so idx+2 past the last pair never wraps back into range.
  localparam int IW = $clog2(K) + 1;

  state_t         state_q;
  logic [W*K-1:0] arr_q;
  logic [IW-1:0]  idx_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   data_q;
  logic           vld_q;
  logic           rdy_q;
  logic           done_q;
  logic [W-1:0]   elem;
  logic           eq;
`ifdef PSI_MATCH_IDX_EN
  logic [$clog2(K)-1:0] oidx_q;
  assign out_idx = oidx_q;
`endif

  psi_pair_select #(.W(W), .K(K), .IW(IW)) u_sel (
    .arr_i  (arr_q),
    .idx_i  (idx_q),
    .elem_o (elem),
    .eq_o   (eq)
  );

  assign in_ready    = rdy_q;
  assign out_data    = data_q;
  assign out_valid   = vld_q;
  assign match_count = cnt_q;
  assign done        = done_q;

  // Control FSM: accept, scan one pair per cycle, hold each match until taken, finish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      arr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef PSI_MATCH_IDX_EN
      oidx_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // in_ready comes up one cycle after reset; accept only once it is visible
          if (rdy_q && in_valid) begin
            arr_q   <= in_array;
            idx_q   <= '0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            state_q <= SCAN;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        SCAN: begin
          if (idx_q > IW'(K - 2)) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (eq) begin
            data_q  <= elem;
            vld_q   <= 1'b1;
`ifdef PSI_MATCH_IDX_EN
            oidx_q  <= idx_q[$clog2(K)-1:0];
`endif
            state_q <= EMIT;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        EMIT: begin
          // A matched pair is consumed as a unit, so skip both elements
          if (out_ready) begin
            vld_q   <= 1'b0;
            idx_q   <= idx_q + IW'(2);
            cnt_q   <= cnt_q + CW'(1);
            state_q <= SCAN;
          end
        end
        DONE: begin
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psi_match_extract.sv
// Directed bench for psi_match_extract: table of arrays for K=8, hand sequences for K=2 and reset mid-emit.
module tb_psi_match_extract;

  localparam int W = 8;
  localparam int K = 8;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // K=8 instance
  logic [W*K-1:0] in_array;
  logic           in_valid, in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid, out_ready;
  logic [2:0]     match_count;
  logic           done;
`ifdef PSI_MATCH_IDX_EN
  logic [2:0]     out_idx;
`endif

  psi_match_extract #(.W(W), .K(K)) dut (
    .clk(clk), .rst(rst), .in_array(in_array), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .match_count(match_count), .done(done)
`ifdef PSI_MATCH_IDX_EN
    , .out_idx(out_idx)
`endif
  );

  // K=2 instance
  logic [15:0] in2;
  logic        iv2, ir2;
  logic [7:0]  od2;
  logic        ov2, or2;
  logic [0:0]  mc2;
  logic        dn2;
`ifdef PSI_MATCH_IDX_EN
  logic [0:0]  oi2;
`endif

  psi_match_extract #(.W(8), .K(2)) dut2 (
    .clk(clk), .rst(rst), .in_array(in2), .in_valid(iv2), .in_ready(ir2),
    .out_data(od2), .out_valid(ov2), .out_ready(or2),
    .match_count(mc2), .done(dn2)
`ifdef PSI_MATCH_IDX_EN
    , .out_idx(oi2)
`endif
  );

  int n_chk;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Element i of arr sits at bits [8i+7:8i]; ed/ei entry j is the j-th expected output.
  typedef struct packed {
    logic [63:0]      arr;
    int               nexp;
    logic [3:0][7:0]  ed;
    logic [3:0][2:0]  ei;
    int               stall;   // cycles out_ready is held low per match
    int               lat;     // expected cycle of done counted from the first SCAN cycle, 0 = unchecked
    bit               poke;    // keep in_valid high with other data while busy
  } vec_t;

  vec_t tv[5];

  task automatic run_vec(input int t);
    vec_t v;
    int n, got, held;
    logic [7:0] hold_d;
    bit seen_done, busy_err, stab_err;
    v = tv[t];
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    chk("in_ready_before_accept", in_ready, 1);
    in_array = v.arr;
    in_valid = 1'b1;
    @(posedge clk); #1;
    if (v.poke) in_array = ~v.arr;
    else        in_valid = 1'b0;
    got = 0; held = 0; n = 0; hold_d = '0;
    seen_done = 0; busy_err = 0; stab_err = 0;
    out_ready = (v.stall == 0);
    while (!seen_done && n < 300) begin
      @(negedge clk); n++;
      if (in_ready) busy_err = 1;
      if (out_valid) begin
        if (held > 0) begin
          if (out_data !== hold_d) stab_err = 1;
        end else begin
          hold_d = out_data;
        end
        if (held < v.stall) begin
          out_ready = 1'b0;
          held++;
        end else begin
          out_ready = 1'b1;
          held = 0;
          if (got < 4) begin
            chk("out_data", out_data, v.ed[got]);
`ifdef PSI_MATCH_IDX_EN
            chk("out_idx", out_idx, v.ei[got]);
`endif
          end
          got++;
        end
      end else begin
        out_ready = (v.stall == 0);
      end
      if (done) begin
        seen_done = 1;
        in_valid  = 1'b0;
      end
    end
    chk("done_seen", seen_done, 1);
    chk("num_outputs", got, v.nexp);
    chk("match_count", match_count, v.nexp);
    chk("busy_in_ready_low", busy_err, 0);
    if (v.lat > 0)   chk("done_latency", n, v.lat);
    if (v.stall > 0) chk("stall_data_stable", stab_err, 0);
    @(negedge clk);
    chk("done_single_pulse", done, 0);
    chk("in_ready_after_done", in_ready, 1);
    chk("match_count_hold", match_count, v.nexp);
  endtask

  task automatic run2(input logic [15:0] arr, input int nexp, input logic [7:0] ed);
    int n, got;
    bit seen;
    n = 0;
    while (!ir2 && n < 20) begin @(negedge clk); n++; end
    chk("k2_in_ready", ir2, 1);
    in2 = arr;
    iv2 = 1'b1;
    @(posedge clk); #1;
    iv2 = 1'b0;
    or2 = 1'b1;
    got = 0; n = 0; seen = 0;
    while (!seen && n < 30) begin
      @(negedge clk); n++;
      if (ov2) begin
        chk("k2_out_data", od2, ed);
`ifdef PSI_MATCH_IDX_EN
        chk("k2_out_idx", oi2, 0);
`endif
        got++;
      end
      if (dn2) seen = 1;
    end
    chk("k2_done_seen", seen, 1);
    chk("k2_num_outputs", got, nexp);
    chk("k2_match_count", mc2, nexp);
  endtask

  initial begin
    int n;
    n_chk = 0; n_fail = 0;
    in_array = '0; in_valid = 1'b0; out_ready = 1'b0;
    in2 = '0; iv2 = 1'b0; or2 = 1'b0;

    // [1,3,3,5,7,7,9,9] -> 3,7,9 at pair starts 1,4,6
    tv[0] = '{arr: 64'h0909070705030301, nexp: 3, ed: {8'd0, 8'd9, 8'd7, 8'd3},
              ei: {3'd0, 3'd6, 3'd4, 3'd1}, stall: 0, lat: 0, poke: 0};
    // [0..7] -> nothing; 8 SCAN cycles then DONE is the 9th
    tv[1] = '{arr: 64'h0706050403020100, nexp: 0, ed: '0, ei: '0, stall: 0, lat: 9, poke: 0};
    // all 4s -> four pairs, stalled 5 cycles each, in_valid pestering while busy
    tv[2] = '{arr: 64'h0404040404040404, nexp: 4, ed: {8'd4, 8'd4, 8'd4, 8'd4},
              ei: {3'd6, 3'd4, 3'd2, 3'd0}, stall: 5, lat: 0, poke: 1};
    // [2,2,2,5,6,8,8,8] runs of three -> greedy pairs at 0 and 5
    tv[3] = '{arr: 64'h0808080605020202, nexp: 2, ed: {8'd0, 8'd0, 8'd8, 8'd2},
              ei: {3'd0, 3'd0, 3'd5, 3'd0}, stall: 0, lat: 0, poke: 0};
    // [5,5,6,7,8,9,10,11] after a mid-emit reset
    tv[4] = '{arr: 64'h0B0A090807060505, nexp: 1, ed: {8'd0, 8'd0, 8'd0, 8'd5},
              ei: '0, stall: 0, lat: 0, poke: 0};

    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_match_count", match_count, 0);
    chk("reset_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 4; t++) run_vec(t);

    run2(16'h0909, 1, 8'd9);
    run2(16'h0902, 0, 8'd0);

    // Reset while a match is waiting on out_ready
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    in_array = 64'h0404040404040404;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk("emit_reached", out_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_async_out_valid", out_valid, 0);
    chk("rst_async_out_data", out_data, 0);
    chk("rst_async_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
